// File: rtl/ddr_game_ctrl.sv
// Game sequencer for the DDR design: owns the RESET/GAME/PAUSE/OVER state,
// counts down game time and lives, and divides the display tick into scroll steps.
module ddr_game_ctrl #(
   parameter int unsigned GAME_SECONDS = 60,
   parameter int unsigned START_LIVES  = 5,
   parameter int unsigned SCROLL_DIV   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       oneHz_tick,
   input  logic       display_tick,
   input  logic       miss_pulse,
   output logic [1:0] state,
   output logic [7:0] time_left,
   output logic [2:0] lives,
   output logic       scroll_step,
   output logic       game_over
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_GAME  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam logic [7:0] TIME_LOAD   = 8'(GAME_SECONDS);
   localparam logic [2:0] LIVES_LOAD  = 3'(START_LIVES);
   localparam logic [7:0] SCROLL_LAST = 8'(SCROLL_DIV - 1);

   state_e     state_q, state_d;
   logic [7:0] time_q, time_d;
   logic [2:0] lives_q, lives_d;
   logic [7:0] scnt_q, scnt_d;
   logic       scroll_q, scroll_d;
   logic       over_q, over_d;
   logic       wrap_s;

   // State register and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RESET;
         time_q   <= TIME_LOAD;
         lives_q  <= LIVES_LOAD;
         scnt_q   <= 8'd0;
         scroll_q <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         time_q   <= time_d;
         lives_q  <= lives_d;
         scnt_q   <= scnt_d;
         scroll_q <= scroll_d;
         over_q   <= over_d;
      end
   end

   // Next-state, counter and pulse logic
   always_comb begin
      state_d  = state_q;
      time_d   = time_q;
      lives_d  = lives_q;
      scnt_d   = scnt_q;
      scroll_d = 1'b0;
      wrap_s   = 1'b0;
      case (state_q)
         ST_RESET: begin
            if (btn_start) state_d = ST_GAME;
            else           state_d = ST_RESET;
         end
         ST_GAME: begin
            if (oneHz_tick && (time_q != 8'd0)) time_d = time_q - 8'd1;
            else                                time_d = time_q;
            if (miss_pulse && (lives_q != 3'd0)) lives_d = lives_q - 3'd1;
            else                                 lives_d = lives_q;
            if (display_tick) begin
               if (scnt_q >= SCROLL_LAST) begin
                  scnt_d = 8'd0;
                  wrap_s = 1'b1;
               end else begin
                  scnt_d = scnt_q + 8'd1;
               end
            end else begin
               scnt_d = scnt_q;
            end
            // Expiry takes precedence over a simultaneous pause request
            if ((time_d == 8'd0) || (lives_d == 3'd0)) state_d = ST_OVER;
            else if (btn_pause)                         state_d = ST_PAUSE;
            else                                        state_d = ST_GAME;
            scroll_d = wrap_s && (state_d == ST_GAME);
         end
         ST_PAUSE: begin
            if (btn_start)      state_d = ST_RESET;
            else if (btn_pause) state_d = ST_GAME;
            else                state_d = ST_PAUSE;
         end
         ST_OVER: begin
            if (btn_start) state_d = ST_RESET;
            else           state_d = ST_OVER;
         end
         default: state_d = ST_RESET;
      endcase
      if (state_d == ST_RESET) begin
         time_d  = TIME_LOAD;
         lives_d = LIVES_LOAD;
         scnt_d  = 8'd0;
      end else begin
         scnt_d  = scnt_d;
      end
      over_d = (state_d == ST_OVER);
   end

   assign state       = state_q;
   assign time_left   = time_q;
   assign lives       = lives_q;
   assign scroll_step = scroll_q;
   assign game_over   = over_q;

endmodule
